data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 94 +++++++++
 tb/tb_data_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder with configurable wait states and a stall/ack handshake,
// used in place of the zero-latency data memory for slow-memory testing.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  ack,
  output logic                  req_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;
  logic                  lat_write;
  logic                  req;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req   = mem_read | mem_write;
  assign stall = ((state == ST_IDLE) && req) || (state == ST_WAIT);

  // Access sequencer; ack is raised on the edge entering DONE so it is high only there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      read_data <= '0;
      ack       <= 1'b0;
      req_err   <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
    end else begin
      ack     <= 1'b0;
      req_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_addr  <= addr;
            lat_data  <= write_data;
            lat_write <= mem_write;
            cnt       <= CNT_W'(WAIT_STATES);
            req_err   <= mem_read & mem_write;
            if (WAIT_STATES != 0) begin
              state <= ST_WAIT;
            end else begin
              // Zero wait states: the latch happens on this same edge, so read straight from addr.
              state <= ST_DONE;
              ack   <= 1'b1;
              if (!mem_write) read_data <= mem[addr];
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
            ack   <= 1'b1;
            if (!lat_write) read_data <= mem[lat_addr];
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes commit on the DONE->IDLE edge; a reset on that edge abandons the store.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_DONE) && lat_write) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states (u0),
// one with 0 wait states (u1), checked cycle by cycle against hand-derived timing.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        rd    [2];
  logic        wr    [2];
  logic [10:0] ad    [2];
  logic [15:0] wd    [2];
  logic [15:0] rdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic        err   [2];
  logic [15:0] last_rd [2];

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]), .addr(ad[0]),
    .write_data(wd[0]), .read_data(rdata[0]), .stall(stall[0]), .ack(ack[0]), .req_err(err[0])
  );

  data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]), .addr(ad[1]),
    .write_data(wd[1]), .read_data(rdata[1]), .stall(stall[1]), .ack(ack[1]), .req_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One access on unit u; inputs are scrambled after acceptance to prove they are latched.
  task automatic access(input int u, input logic r, input logic w, input logic [10:0] a,
                        input logic [15:0] d, input logic e, input logic [15:0] x);
    int ws;
    ws = (u == 0) ? 2 : 0;
    next();
    rd[u] = r; wr[u] = w; ad[u] = a; wd[u] = d;
    #2;
    chk($sformatf("u%0d_stall_c0", u), 32'(stall[u]), 32'd1);
    chk($sformatf("u%0d_ack_c0", u), 32'(ack[u]), 32'd0);
    chk($sformatf("u%0d_err_c0", u), 32'(err[u]), 32'd0);
    chk($sformatf("u%0d_rdata_c0", u), 32'(rdata[u]), 32'(last_rd[u]));
    for (int k = 1; k <= ws + 1; k++) begin
      next();
      if (k == 1) begin
        rd[u] = 1'b0; wr[u] = 1'b0; ad[u] = ~a; wd[u] = ~d;
      end
      #2;
      if (k == ws + 1 && r && !w) last_rd[u] = x;
      chk($sformatf("u%0d_stall_c%0d", u, k), 32'(stall[u]), (k <= ws) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d_ack_c%0d", u, k), 32'(ack[u]), (k <= ws) ? 32'd0 : 32'd1);
      chk($sformatf("u%0d_err_c%0d", u, k), 32'(err[u]), (k == 1) ? 32'(e) : 32'd0);
      chk($sformatf("u%0d_rdata_c%0d", u, k), 32'(rdata[u]), 32'(last_rd[u]));
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0; last_rd[i] = '0;
    end
    next();
    next();
    reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_rdata", i), 32'(rdata[i]), 32'h0);
      chk($sformatf("rst%0d_ack", i), 32'(ack[i]), 32'd0);
      chk($sformatf("rst%0d_stall", i), 32'(stall[i]), 32'd0);
      chk($sformatf("rst%0d_err", i), 32'(err[i]), 32'd0);
    end

    // Two wait states: write then read back.
    access(0, 1'b0, 1'b1, 11'h005, 16'hBEEF, 1'b0, 16'h0);
    access(0, 1'b1, 1'b0, 11'h005, 16'h0000, 1'b0, 16'hBEEF);

    // Zero wait states at the top address.
    access(1, 1'b0, 1'b1, 11'h7FF, 16'h1234, 1'b0, 16'h0);
    access(1, 1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b0, 16'h1234);

    // Simultaneous read and write is treated as a write and flagged.
    access(0, 1'b1, 1'b1, 11'h010, 16'h00AA, 1'b1, 16'h0);
    access(0, 1'b1, 1'b0, 11'h010, 16'h0000, 1'b0, 16'h00AA);
    access(1, 1'b1, 1'b1, 11'h010, 16'h5A5A, 1'b1, 16'h0);
    access(1, 1'b1, 1'b0, 11'h010, 16'h0000, 1'b0, 16'h5A5A);

    // Reset during WAIT abandons the pending store.
    access(0, 1'b0, 1'b1, 11'h020, 16'h0001, 1'b0, 16'h0);
    next();
    wr[0] = 1'b1; ad[0] = 11'h020; wd[0] = 16'hFFFF;
    #2;
    chk("abort_stall_c0", 32'(stall[0]), 32'd1);
    next();
    wr[0] = 1'b0; ad[0] = '0; wd[0] = '0;
    #2;
    chk("abort_stall_c1", 32'(stall[0]), 32'd1);
    chk("abort_ack_c1", 32'(ack[0]), 32'd0);
    next();
    reset = 1'b1;
    #2;
    chk("abort_stall_c2", 32'(stall[0]), 32'd1);
    chk("abort_ack_c2", 32'(ack[0]), 32'd0);
    next();
    reset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    #2;
    chk("abort_ack_c3", 32'(ack[0]), 32'd0);
    chk("abort_stall_c3", 32'(stall[0]), 32'd0);
    chk("abort_rdata_c3", 32'(rdata[0]), 32'h0);
    chk("abort_u1_rdata", 32'(rdata[1]), 32'h0);
    next();
    #2;
    chk("abort_ack_c4", 32'(ack[0]), 32'd0);
    access(0, 1'b1, 1'b0, 11'h020, 16'h0000, 1'b0, 16'h0001);

    // Back-to-back reads at both address extremes; a write in between must not disturb read_data.
    access(0, 1'b0, 1'b1, 11'h000, 16'h1111, 1'b0, 16'h0);
    access(0, 1'b0, 1'b1, 11'h7FF, 16'h2222, 1'b0, 16'h0);
    access(0, 1'b1, 1'b0, 11'h000, 16'h0000, 1'b0, 16'h1111);
    access(0, 1'b1, 1'b0, 11'h7FF, 16'h0000, 1'b0, 16'h2222);
    access(0, 1'b1, 1'b0, 11'h005, 16'h0000, 1'b0, 16'hBEEF);

    next();
    #2;
    chk("final_idle_ack", 32'(ack[0]), 32'd0);
    chk("final_idle_stall", 32'(stall[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
